// File: rtl/single_divide_v_s_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : single_pkg                                                      |
// | Purpose  : Shared types and helpers for the vector-by-scalar divide        |
// |            sequencer: float32 alias, sequencer state encoding, IEEE-754    |
// |            special-value constants and a zero/denormal test.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package single_pkg;

    typedef logic [31:0] float32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam float32_t FP_POS_INF = 32'h7F80_0000;
    localparam float32_t FP_QNAN    = 32'h7FC0_0000;

    // Zero exponent covers both signed zeros and denormals, which the
    // sequencer treats alike as a zero operand.
    function automatic logic fp_is_zero(input float32_t f);
        return (f[30:23] == 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/single_divide_v_s_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : single_divide_v_s_seq_if                                        |
// | Purpose  : Bundles the job input handshake, result output handshake,       |
// |            shared-divider port and status flags of the sequencer.          |
// |            slave  : sequencer view                                         |
// |            master : environment view (producer, consumer and divider)      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface single_divide_v_s_seq_if
    import single_pkg::*;
#(
    parameter int WIDTH = 10
);

    logic                   in_valid;
    logic                   in_ready;
    float32_t [WIDTH-1:0]   vector_a;
    float32_t               b;
    logic                   out_valid;
    logic                   out_ready;
    float32_t [WIDTH-1:0]   vector_c;
    logic                   div_in_valid;
    float32_t               div_a;
    float32_t               div_b;
    logic                   div_out_valid;
    float32_t               div_c;
    logic                   protocol_err;
    logic                   div_zero;

    modport slave (
        input  in_valid, vector_a, b, out_ready, div_out_valid, div_c,
        output in_ready, out_valid, vector_c, div_in_valid, div_a, div_b,
               protocol_err, div_zero
    );

    modport master (
        output in_valid, vector_a, b, out_ready, div_out_valid, div_c,
        input  in_ready, out_valid, vector_c, div_in_valid, div_a, div_b,
               protocol_err, div_zero
    );

endinterface
`default_nettype wire

// File: rtl/single_divide_v_s_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : single_divide_v_s_seq                                           |
// | Purpose  : Time-multiplexes one pipelined single-precision divider across  |
// |            a WIDTH-element vector divided by a scalar. Accepts a job,      |
// |            issues one element per cycle, collects results in arrival       |
// |            order (latency-agnostic) and presents the full quotient vector. |
// | Ports    : clk, rst         - clock, synchronous active-high reset         |
// |            bus (slave)      - in_valid/in_ready/vector_a/b job input,      |
// |                               out_valid/out_ready/vector_c result output,  |
// |                               div_in_valid/div_a/div_b/div_out_valid/div_c |
// |                               divider port, protocol_err, div_zero         |
// | Options  : SINGLE_DIV_SEQ_ZERO_CHECK_EN - zero-divisor bypass producing    |
// |            signed infinity / quiet NaN without using the divider.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module single_divide_v_s_seq
    import single_pkg::*;
#(
    parameter int WIDTH = 10
)(
    input  wire logic               clk,
    input  wire logic               rst,
    single_divide_v_s_seq_if.slave  bus
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WIDTH - 1);

    seq_state_t             r_state;
    seq_state_t             w_state_next;
    logic [IDX_W-1:0]       r_issue_idx;
    logic [IDX_W-1:0]       r_collect_idx;
    logic [CNT_W-1:0]       r_outstanding;
    float32_t [WIDTH-1:0]   r_a;
    float32_t               r_b;
    float32_t [WIDTH-1:0]   r_vector_c;
    logic                   r_protocol_err;

    logic                   w_accept;
    logic                   w_issue;
    logic                   w_collect;
    logic                   w_stray;
    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_b_zero;
    logic                   w_fill_pending;

`ifdef SINGLE_DIV_SEQ_ZERO_CHECK_EN
    logic                   r_div_zero;
    // High for the first DONE cycle of a zero-divisor job while the
    // special-value results are written; out_valid is held off meanwhile.
    logic                   r_zero_fill;

    assign w_b_zero       = fp_is_zero(bus.b);
    assign w_fill_pending = r_zero_fill;
    assign bus.div_zero   = r_div_zero;
`else
    assign w_b_zero       = 1'b0;
    assign w_fill_pending = 1'b0;
    assign bus.div_zero   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_collect    = 1'b0;
        w_stray      = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_b_zero ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                w_issue = 1'b1;
                if (r_issue_idx == c_last_idx) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
            end
            DONE: begin
                w_out_valid = !w_fill_pending;
                if (bus.out_ready && !w_fill_pending) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // Outstanding excludes this cycle's issue, so a zero-latency result
        // can never be credited against an operand not yet registered.
        if (bus.div_out_valid) begin
            if (r_outstanding == '0) begin
                w_stray = 1'b1;
            end else if (r_state == ISSUE || r_state == DRAIN) begin
                w_collect = 1'b1;
                if (r_collect_idx == c_last_idx) begin
                    w_state_next = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_idx    <= '0;
            r_collect_idx  <= '0;
            r_outstanding  <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_vector_c     <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a           <= bus.vector_a;
                r_b           <= bus.b;
                r_issue_idx   <= '0;
                r_collect_idx <= '0;
            end
            if (w_issue) begin
                r_issue_idx <= r_issue_idx + IDX_W'(1);
            end
            if (w_collect) begin
                r_vector_c[r_collect_idx] <= bus.div_c;
                r_collect_idx             <= r_collect_idx + IDX_W'(1);
            end
            r_outstanding <= r_outstanding + CNT_W'(w_issue) - CNT_W'(w_collect);
            if (w_stray) begin
                r_protocol_err <= 1'b1;
            end
`ifdef SINGLE_DIV_SEQ_ZERO_CHECK_EN
            if (r_zero_fill) begin
                for (int i = 0; i < WIDTH; i++) begin
                    r_vector_c[i] <= fp_is_zero(r_a[i]) ? FP_QNAN
                                   : {r_a[i][31] ^ r_b[31], FP_POS_INF[30:0]};
                end
            end
`endif
        end
    end

`ifdef SINGLE_DIV_SEQ_ZERO_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_zero  <= 1'b0;
            r_zero_fill <= 1'b0;
        end else if (w_accept) begin
            r_div_zero  <= w_b_zero;
            r_zero_fill <= w_b_zero;
        end else begin
            r_zero_fill <= 1'b0;
        end
    end
`endif

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.vector_c     = r_vector_c;
    assign bus.div_in_valid = w_issue;
    assign bus.div_a        = w_issue ? r_a[r_issue_idx] : '0;
    assign bus.div_b        = w_issue ? r_b : '0;
    assign bus.protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_single_divide_v_s_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_single_divide_v_s_seq                                        |
// | Purpose  : Self-checking bench for single_divide_v_s_seq with a queue-     |
// |            based variable-latency divider model. Honours                   |
// |            SINGLE_DIV_SEQ_ZERO_CHECK_EN for the zero-divisor scenario.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_single_divide_v_s_seq;
    import single_pkg::*;

    localparam int WIDTH = 10;
    localparam int VW    = 32 * WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    single_divide_v_s_seq_if #(.WIDTH(WIDTH)) bus ();

    single_divide_v_s_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Divider stand-in: exact halving when b is 2.0 and a is an ordinary
    // normal number, otherwise a deterministic surrogate "quotient".
    function automatic float32_t ref_div(input float32_t a, input float32_t b);
        if (b == 32'h4000_0000 && a[30:23] > 8'd1 && a[30:23] != 8'hFF)
            return a - 32'h0080_0000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [VW-1:0] pack(input float32_t e [WIDTH]);
        logic [VW-1:0] v;
        for (int i = 0; i < WIDTH; i++) v[i*32 +: 32] = e[i];
        return v;
    endfunction

    // ---------------- divider model: results due lat cycles after issue ----
    typedef struct { float32_t q; int unsigned due; } pend_t;
    pend_t       pend [$];
    int          lat = 3;
    int unsigned cyc = 0;
    bit          stray_req = 1'b0;

    initial begin
        logic        s_rst, s_v;
        float32_t    s_a, s_b;
        int unsigned s_cyc;
        pend_t       e;
        bus.div_out_valid = 1'b0;
        bus.div_c         = '0;
        forever begin
            @(negedge clk);
            s_rst = rst; s_v = bus.div_in_valid; s_a = bus.div_a; s_b = bus.div_b; s_cyc = cyc;
            @(posedge clk);
            #1;
            cyc = s_cyc + 1;
            bus.div_out_valid = 1'b0;
            bus.div_c         = '0;
            if (s_rst) begin
                pend.delete();
            end else begin
                if (s_v) begin
                    e.q = ref_div(s_a, s_b);
                    e.due = s_cyc + lat;
                    pend.push_back(e);
                end
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    bus.div_out_valid = 1'b1;
                    bus.div_c         = pend[0].q;
                    void'(pend.pop_front());
                end else if (stray_req) begin
                    bus.div_out_valid = 1'b1;
                    bus.div_c         = 32'hDEAD_BEEF;
                    stray_req         = 1'b0;
                end
            end
        end
    end

    // ---------------- one complete job with optional back-pressure ---------
    task automatic run_job(input string tag, input logic [VW-1:0] a, input float32_t b,
                           input int l, input logic [VW-1:0] exp_c, input int hold,
                           input bit exp_perr);
        int            issues = 0;
        int            cnt;
        logic [VW-1:0] snap;
        lat = l;
        check({tag, " in_ready"}, VW'(bus.in_ready), VW'(1));
        bus.vector_a = a; bus.b = b; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.vector_a = '0; bus.b = '0;
        cnt = 1;
        while (!bus.out_valid && cnt <= 200) begin
            if (bus.div_in_valid) issues++;
            step();
            cnt++;
        end
        check({tag, " out_valid seen"}, VW'(bus.out_valid), VW'(1));
        check({tag, " result latency"}, VW'(cnt), VW'(WIDTH + l + 1));
        check({tag, " issue count"}, VW'(issues), VW'(WIDTH));
        check({tag, " vector_c"}, bus.vector_c, exp_c);
        check({tag, " div_zero"}, VW'(bus.div_zero), VW'(0));
        check({tag, " protocol_err"}, VW'(bus.protocol_err), VW'(exp_perr));
        snap   = bus.vector_c;
        issues = 0;
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                bus.in_valid = 1'b1; bus.vector_a = ~a; bus.b = 32'h3F80_0000;
                check({tag, " busy in_ready"}, VW'(bus.in_ready), VW'(0));
            end
            step();
            bus.in_valid = 1'b0;
            if (bus.div_in_valid) issues++;
        end
        if (hold > 0) begin
            check({tag, " held out_valid"}, VW'(bus.out_valid), VW'(1));
            check({tag, " held vector_c"}, bus.vector_c, snap);
            check({tag, " held no issue"}, VW'(issues), VW'(0));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, " post out_valid"}, VW'(bus.out_valid), VW'(0));
        check({tag, " post in_ready"}, VW'(bus.in_ready), VW'(1));
    endtask

    typedef struct {
        float32_t a [WIDTH];
        float32_t b;
        int       lat;
        float32_t c [WIDTH];
        int       hold;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t          tbl [4];
        float32_t      ra [WIDTH];
        float32_t      rc [WIDTH];
        float32_t      rb;
        logic [VW-1:0] tmp;

        tbl[0].a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                     32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
        tbl[0].c = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40200000,
                     32'h40400000, 32'h40600000, 32'h40800000, 32'h40900000, 32'h40A00000};
        tbl[0].b = 32'h40000000; tbl[0].lat = 3; tbl[0].hold = 5;
        tbl[1] = tbl[0]; tbl[1].lat = 1;  tbl[1].hold = 0;
        tbl[2] = tbl[0]; tbl[2].lat = 20; tbl[2].hold = 3;
        tbl[3].a = '{32'hC0400000, 32'h3E800000, 32'h42C80000, 32'hBF800000, 32'h44800000,
                     32'h3DCCCCCD, 32'hC1200000, 32'h40490FDB, 32'h3F000000, 32'h47000000};
        tbl[3].c = '{32'hBFC00000, 32'h3E000000, 32'h42480000, 32'hBF000000, 32'h44000000,
                     32'h3D4CCCCD, 32'hC0A00000, 32'h3FC90FDB, 32'h3E800000, 32'h46800000};
        tbl[3].b = 32'h40000000; tbl[3].lat = 2; tbl[3].hold = 1;

        bus.in_valid = 1'b0; bus.vector_a = '0; bus.b = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("reset in_ready", VW'(bus.in_ready), VW'(1));
        check("reset out_valid", VW'(bus.out_valid), VW'(0));
        check("reset div_in_valid", VW'(bus.div_in_valid), VW'(0));
        check("reset div_a", VW'(bus.div_a), VW'(0));
        check("reset div_b", VW'(bus.div_b), VW'(0));
        check("reset vector_c", bus.vector_c, '0);
        check("reset protocol_err", VW'(bus.protocol_err), VW'(0));
        check("reset div_zero", VW'(bus.div_zero), VW'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++)
            run_job($sformatf("tbl%0d", i), pack(tbl[i].a), tbl[i].b, tbl[i].lat,
                    pack(tbl[i].c), tbl[i].hold, 1'b0);

        for (int j = 0; j < 6; j++) begin
            rb = $urandom;
            rb[30:23] = 8'($urandom_range(1, 254));
            for (int i = 0; i < WIDTH; i++) begin
                ra[i] = $urandom;
                rc[i] = ref_div(ra[i], rb);
            end
            run_job($sformatf("rand%0d", j), pack(ra), rb, int'($urandom_range(1, 24)),
                    pack(rc), int'($urandom_range(0, 4)), 1'b0);
        end

        // stray result in IDLE: sticky error that survives a good job
        stray_req = 1'b1;
        step();
        step();
        check("stray protocol_err", VW'(bus.protocol_err), VW'(1));
        check("stray vector_c kept", bus.vector_c, pack(rc));
        run_job("after_stray", pack(tbl[0].a), tbl[0].b, 4, pack(tbl[0].c), 0, 1'b1);
        rst = 1'b1;
        step();
        check("rst clears protocol_err", VW'(bus.protocol_err), VW'(0));
        rst = 1'b0;
        step();

        // reset while issuing element 4
        lat = 3;
        bus.vector_a = pack(tbl[0].a); bus.b = tbl[0].b; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        tmp = pack(tbl[0].a);
        check("midjob issuing", VW'(bus.div_in_valid), VW'(1));
        check("midjob div_a idx4", VW'(bus.div_a), VW'(tmp[4*32 +: 32]));
        rst = 1'b1;
        step();
        check("midrst in_ready", VW'(bus.in_ready), VW'(1));
        check("midrst out_valid", VW'(bus.out_valid), VW'(0));
        check("midrst div_in_valid", VW'(bus.div_in_valid), VW'(0));
        check("midrst vector_c", bus.vector_c, '0);
        rst = 1'b0;
        step();
        run_job("after_midrst", pack(tbl[3].a), tbl[3].b, 3, pack(tbl[3].c), 2, 1'b0);

`ifdef SINGLE_DIV_SEQ_ZERO_CHECK_EN
        begin
            int issues = 0;
            int cnt;
            ra = '{32'hC0400000, 32'h00000000, 32'h40A00000, 32'h80000000, 32'h00012345,
                   32'h3F800000, 32'hBF800000, 32'h42C80000, 32'hC2C80000, 32'h7F000000};
            for (int i = 0; i < WIDTH; i++)
                rc[i] = (ra[i][30:23] == 8'd0) ? 32'h7FC00000 : (ra[i][31] ? 32'hFF800000 : 32'h7F800000);
            bus.vector_a = pack(ra); bus.b = 32'h0000_0000; bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            cnt = 1;
            while (!bus.out_valid && cnt <= 50) begin
                if (bus.div_in_valid) issues++;
                step();
                cnt++;
            end
            check("zero out_valid latency", VW'(cnt), VW'(2));
            check("zero no issue", VW'(issues), VW'(0));
            check("zero div_zero", VW'(bus.div_zero), VW'(1));
            check("zero vector_c", bus.vector_c, pack(rc));
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            run_job("zero_cleared", pack(tbl[0].a), tbl[0].b, 3, pack(tbl[0].c), 0, 1'b0);
        end
`else
        for (int i = 0; i < WIDTH; i++) begin
            ra[i] = $urandom;
            rc[i] = ref_div(ra[i], 32'h0000_0000);
        end
        run_job("zero_b_passthru", pack(ra), 32'h0000_0000, 5, pack(rc), 0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/single_divide_v_s_seq.md
Name: single_divide_v_s_seq

Overview:
Sequencer that time-multiplexes one pipelined single-precision divider across a WIDTH-element vector divided by a scalar. It accepts a whole vector and the scalar with a valid/ready handshake. It then issues one element per cycle to an external divider, collects the results in order, and presents the complete result vector with a valid/ready handshake. It is the area-saving alternative to instantiating one divider per element, and sits between layer-normalisation logic and the shared divider.

Parameters:
WIDTH, 10, number of vector elements; must be >= 1
IDX_W, $clog2(WIDTH) (min 1), localparam; width of the issue/collect indices

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  vector_a and b are valid
in_ready  out  1  block is idle and can accept a job
vector_a  in  32 x WIDTH  dividend vector, IEEE-754 single
b  in  32  divisor, IEEE-754 single
out_valid  out  1  vector_c holds a complete result
out_ready  in  1  consumer accepts vector_c
vector_c  out  32 x WIDTH  quotient vector, registered
div_in_valid  out  1  to divider: operand pair valid
div_a  out  32  to divider: dividend
div_b  out  32  to divider: divisor
div_out_valid  in  1  from divider: result valid
div_c  in  32  from divider: quotient
protocol_err  out  1  sticky: divider result arrived when none was outstanding
div_zero  out  1  current job had a zero divisor (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high; rst has priority over all other events):
  - state=IDLE, indices=0, in_ready=1, out_valid=0, div_in_valid=0.
  - div_a=div_b=0, vector_c all 0, protocol_err=0, div_zero=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch vector_a and b into internal registers and go to ISSUE.
  - ISSUE: each cycle drive div_in_valid=1, div_a=a_reg[issue_idx], div_b=b_reg, then increment issue_idx. After issuing index WIDTH-1, go to DRAIN (same cycle as that issue; div_in_valid drops next cycle).
  - DRAIN: div_in_valid=0. Wait for the remaining results.
  - DONE: out_valid=1; vector_c is stable. On out_ready, go to IDLE with out_valid=0 next cycle.
- Issue timing: handshake in cycle N gives issues in cycles N+1..N+WIDTH.
- Collection (active in ISSUE and DRAIN):
  - The divider latency is not assumed; results are counted by div_out_valid.
  - Each div_out_valid writes div_c into vector_c[collect_idx], then collect_idx increments.
  - On the collection of index WIDTH-1, go to DONE; out_valid=1 the following cycle.
  - Results may arrive while still in ISSUE (latency < WIDTH); a final collection in the same cycle as the last issue is legal only if outstanding=0 would not underflow.
- Outstanding count (issued minus collected):
  - div_out_valid with outstanding==0 in any state sets protocol_err (sticky until rst), and the data is dropped.
  - protocol_err also covers stray results after a mid-job reset.
- in_valid while not IDLE: in_ready=0 and the input is ignored, with no latching.
- Back-to-back jobs: in_ready returns the cycle after the out_valid&&out_ready handshake, giving a minimum job period of WIDTH+latency+2 cycles.
- Reset mid-operation: abandon the job and return to IDLE next cycle. The divider must be reset by the same reset event.
- WIDTH=1: ISSUE lasts exactly one cycle.

Optional Feature:
- Macro: SINGLE_DIV_SEQ_ZERO_CHECK_EN.
- Defined:
  - At acceptance, b with exponent==0 (±0 or denormal) sets div_zero=1 and the block skips ISSUE/DRAIN, going directly to DONE; no div_in_valid is issued.
  - vector_c[i] = {a_sign^b_sign, 31'h7F800000} (signed infinity). If a_reg[i] is also zero (exponent==0), vector_c[i]=32'h7FC00000 (quiet NaN).
  - out_valid=1 two cycles after the input handshake.
  - div_zero clears on the next accepted job.
- Undefined: b is always sent to the divider and div_zero is tied 0.

Decomposition:
- Package single_pkg: typedef float32_t (logic [31:0]), state enum seq_state_t {IDLE, ISSUE, DRAIN, DONE}, constants FP_POS_INF=32'h7F800000 and FP_QNAN=32'h7FC00000, and a function fp_is_zero(float32_t).
- No sub-module is needed. The issue and collect counters are simple and stay inline.

Test Plan:
- Basic job: WIDTH=10, a={1.0..10.0} (0x3F800000, 0x40000000, ...), b=2.0 (0x40000000), divider latency 3 -> vector_c={0.5..5.0} (0x3F000000 ... 0x40A00000); out_valid at cycle N+WIDTH+3+1; div_in_valid high exactly 10 cycles.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> vector_c stable and out_valid held; in_valid pulsed during this window is ignored (in_ready=0); the next job starts only after the handshake.
- Latency sweep: divider latency 1 and 20 -> identical results and in-order placement; zero dropped results.
- Protocol error: inject div_out_valid in IDLE -> protocol_err=1 and it stays 1 through a subsequent good job; rst clears it.
- Reset mid-job: assert rst in ISSUE at issue_idx=4 -> IDLE next cycle, in_ready=1, vector_c=0; a fresh job afterwards produces correct results.
- With SINGLE_DIV_SEQ_ZERO_CHECK_EN: a={-3.0, 0.0, 5.0, ...}, b=0x00000000 -> vector_c={0xFF800000, 0x7FC00000, 0x7F800000, ...}, div_zero=1, no div_in_valid, out_valid two cycles after the handshake.
